// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man map datapath: cell codes, writer states
// and default map geometry.
package pacman_pkg;

  localparam int MAP_W_DEF = 40;
  localparam int MAP_H_DEF = 30;

  localparam logic [3:0] CELL_EMPTY  = 4'd0;
  localparam logic [3:0] CELL_WALL   = 4'd1;
  localparam logic [3:0] CELL_PILL   = 4'd2;
  localparam logic [3:0] CELL_PACMAN = 4'd3;

  typedef enum logic [2:0] {
    IDLE,
    PACE,
    ERASE,
    WRITE,
    DONE
  } writer_state_t;

endpackage

// File: rtl/pacman_map_writer_map_addr_calc.sv
// Combinational cell-to-address mapping: addr = y*MAP_W + x, row-major.
module map_addr_calc
  import pacman_pkg::*;
#(
  parameter int MAP_W  = MAP_W_DEF,
  parameter int ADDR_W = 11
) (
  input  logic [5:0]        x,
  input  logic [4:0]        y,
  output logic [ADDR_W-1:0] addr
);

  // Widen both operands before the multiply so in-range rows never truncate.
  assign addr = ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);

endmodule

// File: rtl/pacman_map_writer.sv
// Writes each accepted Pac-Man move into the map RAM: paces, erases the old
// cell, writes the new one, then pulses done for the location controller.
//
// state | meaning
// IDLE  | waiting for next != curr
// PACE  | speed-limiting delay before touching the RAM
// ERASE | writing CELL_EMPTY at latched curr, held while ram_busy
// WRITE | writing CELL_PACMAN at latched next, held while ram_busy
// DONE  | one-cycle done pulse, location controller commits next
module pacman_map_writer
  import pacman_pkg::*;
#(
  parameter int MAP_W      = MAP_W_DEF,
  parameter int MAP_H      = MAP_H_DEF,
  parameter int ADDR_W     = 11,
  parameter int CELL_W     = 4,
  parameter int MOVE_DELAY = 2500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [5:0]        curr_pacman_x,
  input  logic [4:0]        curr_pacman_y,
  input  logic [5:0]        next_pacman_x,
  input  logic [4:0]        next_pacman_y,
  input  logic              ram_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CELL_W-1:0] wr_data,
  output logic              done,
  output logic              busy,
  output logic              oob_err
);

  localparam int CNT_W = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;
  localparam logic [CNT_W-1:0] PACE_LAST = CNT_W'(MOVE_DELAY - 1);

  writer_state_t     state, state_nxt;
  logic [5:0]        curr_x_q, next_x_q;
  logic [4:0]        curr_y_q, next_y_q;
  logic [CNT_W-1:0]  pace_cnt;
  logic [ADDR_W-1:0] curr_addr, next_addr;
  logic              move_req, next_oob, pace_end;

  assign move_req = (next_pacman_x != curr_pacman_x) || (next_pacman_y != curr_pacman_y);
  assign next_oob = (int'(next_x_q) >= MAP_W) || (int'(next_y_q) >= MAP_H);
  assign pace_end = (pace_cnt == PACE_LAST);
  assign busy     = (state != IDLE);

  // Addresses come straight off the latched coordinates, so they are ready
  // the moment ERASE/WRITE is entered.
  map_addr_calc #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_curr_addr (
    .x    (curr_x_q),
    .y    (curr_y_q),
    .addr (curr_addr)
  );

  map_addr_calc #(.MAP_W(MAP_W), .ADDR_W(ADDR_W)) u_next_addr (
    .x    (next_x_q),
    .y    (next_y_q),
    .addr (next_addr)
  );

  // State register; reset aborts any move in flight without a done pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Coordinate latch, pace counter and sticky out-of-range flag.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      curr_x_q <= '0;
      curr_y_q <= '0;
      next_x_q <= '0;
      next_y_q <= '0;
      pace_cnt <= '0;
      oob_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (move_req) begin
            curr_x_q <= curr_pacman_x;
            curr_y_q <= curr_pacman_y;
            next_x_q <= next_pacman_x;
            next_y_q <= next_pacman_y;
            pace_cnt <= '0;
          end
        end
        PACE: begin
          if (!pace_end)     pace_cnt <= pace_cnt + CNT_W'(1);
          if (pace_end && next_oob) oob_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and RAM port drive; outputs depend only on state so they stay
  // stable across ram_busy stalls.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = CELL_W'(CELL_EMPTY);
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (move_req) state_nxt = PACE;
      end
      PACE: begin
        if (pace_end) state_nxt = next_oob ? DONE : ERASE;
      end
      ERASE: begin
        wr_en   = 1'b1;
        wr_addr = curr_addr;
        wr_data = CELL_W'(CELL_EMPTY);
        if (!ram_busy) state_nxt = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_addr = next_addr;
        wr_data = CELL_W'(CELL_PACMAN);
        if (!ram_busy) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pacman_map_writer.sv
// Bench for pacman_map_writer: directed scenarios plus random moves and RAM
// stalls, checked cycle by cycle against a queue-based move model.
module tb_pacman_map_writer;
  import pacman_pkg::*;

  localparam int MD = 4;
  localparam int MW = 40;
  localparam int MH = 30;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [5:0]  curr_pacman_x, next_pacman_x;
  logic [4:0]  curr_pacman_y, next_pacman_y;
  logic        ram_busy;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [3:0]  wr_data;
  logic        done, busy, oob_err;

  pacman_map_writer #(
    .MAP_W(MW), .MAP_H(MH), .ADDR_W(11), .CELL_W(4), .MOVE_DELAY(MD)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .curr_pacman_x (curr_pacman_x),
    .curr_pacman_y (curr_pacman_y),
    .next_pacman_x (next_pacman_x),
    .next_pacman_y (next_pacman_y),
    .ram_busy      (ram_busy),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .done          (done),
    .busy          (busy),
    .oob_err       (oob_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Move model: a move is a pacing count followed by a queue of RAM writes
  // that drain one per non-busy cycle, then a single done cycle.
  bit m_active = 0;
  bit m_oob_move = 0;
  bit m_oob = 0;
  int m_pace = 0;
  int m_wq_addr[$];
  int m_wq_data[$];

  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_wr_cyc = 0;
  int last_done_cyc = -1;
  int acc_addr[$];
  int acc_data[$];
  int acc_cyc[$];

  function automatic int cell_addr(input int x, input int y);
    return (y * MW + x) % 2048;
  endfunction

  task automatic clr_obs();
    n_acc = 0; n_done = 0; n_wr_cyc = 0; last_done_cyc = -1;
    acc_addr.delete(); acc_data.delete(); acc_cyc.delete();
  endtask

  task automatic set_pos(input int cx, input int cy, input int nx, input int ny);
    curr_pacman_x = 6'(cx); curr_pacman_y = 5'(cy);
    next_pacman_x = 6'(nx); next_pacman_y = 5'(ny);
  endtask

  // Called just after a falling edge with inputs already set: checks this
  // cycle's outputs, advances the model over the rising edge, then emulates
  // the location controller committing next into curr on done.
  task automatic tick();
    bit e_wr, e_done;
    e_wr   = m_active && (m_pace == 0) && (m_wq_addr.size() > 0);
    e_done = m_active && (m_pace == 0) && (m_wq_addr.size() == 0);
    chk("wr_en", wr_en, e_wr);
    chk("done", done, e_done);
    chk("busy", busy, m_active);
    chk("oob_err", oob_err, m_oob);
    if (e_wr) begin
      chk("wr_addr", wr_addr, m_wq_addr[0]);
      chk("wr_data", wr_data, m_wq_data[0]);
    end
    if (wr_en) n_wr_cyc++;
    if (wr_en && !ram_busy && !reset) begin
      n_acc++;
      acc_addr.push_back(int'(wr_addr));
      acc_data.push_back(int'(wr_data));
      acc_cyc.push_back(cyc);
    end
    if (done) begin n_done++; last_done_cyc = cyc; end

    if (reset) begin
      m_active = 0; m_oob = 0; m_pace = 0;
      m_wq_addr.delete(); m_wq_data.delete();
    end else if (!m_active) begin
      if (curr_pacman_x != next_pacman_x || curr_pacman_y != next_pacman_y) begin
        m_active   = 1;
        m_pace     = MD;
        m_oob_move = (int'(next_pacman_x) >= MW) || (int'(next_pacman_y) >= MH);
        if (!m_oob_move) begin
          m_wq_addr.push_back(cell_addr(curr_pacman_x, curr_pacman_y));
          m_wq_data.push_back(int'(CELL_EMPTY));
          m_wq_addr.push_back(cell_addr(next_pacman_x, next_pacman_y));
          m_wq_data.push_back(int'(CELL_PACMAN));
        end
      end
    end else if (m_pace > 0) begin
      m_pace--;
      if (m_pace == 0 && m_oob_move) m_oob = 1;
    end else if (m_wq_addr.size() > 0) begin
      if (!ram_busy) begin
        void'(m_wq_addr.pop_front());
        void'(m_wq_data.pop_front());
      end
    end else begin
      m_active = 0;
    end

    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    if (e_done && !reset) begin
      curr_pacman_x = next_pacman_x;
      curr_pacman_y = next_pacman_y;
    end
    cyc++;
  endtask

  int req;

  initial begin
    reset = 1'b1;
    ram_busy = 1'b0;
    set_pos(20, 20, 20, 20);
    @(negedge CLOCK_50);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, CELL_EMPTY);

    // Reset held with no pending move.
    clr_obs();
    repeat (10) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("idle_wr_cycles", n_wr_cyc, 0);
    chk("idle_done", n_done, 0);

    // Plain move, no stalls.
    clr_obs();
    set_pos(20, 20, 20, 19);
    req = cyc;
    repeat (10) tick();
    chk("mv_acc_n", acc_addr.size(), 2);
    if (acc_addr.size() >= 2) begin
      chk("mv_erase_addr", acc_addr[0], 820);
      chk("mv_erase_data", acc_data[0], 0);
      chk("mv_write_addr", acc_addr[1], 780);
      chk("mv_write_data", acc_data[1], 3);
      chk("mv_write_gap", acc_cyc[1] - acc_cyc[0], 1);
    end
    chk("mv_done_cnt", n_done, 1);
    chk("mv_latency", last_done_cyc - req, 7);

    // Same move with a three-cycle stall in ERASE.
    clr_obs();
    set_pos(20, 20, 20, 19);
    req = cyc;
    repeat (5) tick();
    ram_busy = 1'b1;
    repeat (3) tick();
    ram_busy = 1'b0;
    repeat (6) tick();
    chk("stall_acc_n", n_acc, 2);
    chk("stall_wr_cycles", n_wr_cyc, 5);
    chk("stall_latency", last_done_cyc - req, 10);

    // next changes mid-PACE; the latched target must be used.
    clr_obs();
    set_pos(20, 20, 20, 19);
    req = cyc;
    repeat (2) tick();
    next_pacman_x = 6'd21; next_pacman_y = 5'd20;
    repeat (10) tick();
    chk("midp_acc_n", acc_addr.size(), 2);
    if (acc_addr.size() >= 2) begin
      chk("midp_erase_addr", acc_addr[0], 820);
      chk("midp_write_addr", acc_addr[1], 780);
    end
    repeat (6) tick();
    chk("midp_done_cnt", n_done, 1);
    chk("midp_no_rerun", n_acc, 2);

    // Out-of-range target.
    clr_obs();
    set_pos(21, 20, 45, 20);
    req = cyc;
    repeat (8) tick();
    chk("oob_acc_n", n_wr_cyc, 0);
    chk("oob_done_cnt", n_done, 1);
    chk("oob_latency", last_done_cyc - req, 5);
    repeat (5) tick();
    chk("oob_sticky", oob_err, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_pos(20, 20, 20, 20);
    chk("oob_cleared", oob_err, 0);
    repeat (2) tick();

    // Reset during a WRITE stall aborts with no done.
    clr_obs();
    set_pos(20, 20, 20, 19);
    repeat (6) tick();
    ram_busy = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ram_busy = 1'b0;
    set_pos(20, 20, 20, 20);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    repeat (4) tick();
    chk("abort_done_cnt", n_done, 0);

    // Random moves, stalls, mid-move input changes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      ram_busy = ($urandom_range(0, 99) < 35);
      reset    = ($urandom_range(0, 199) == 0);
      if (!m_active && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          next_pacman_x = curr_pacman_x;
          next_pacman_y = curr_pacman_y;
        end else begin
          next_pacman_x = 6'($urandom_range(0, 47));
          next_pacman_y = 5'($urandom_range(0, 31));
        end
      end else if ($urandom_range(0, 15) == 0) begin
        next_pacman_x = 6'($urandom_range(0, 47));
        next_pacman_y = 5'($urandom_range(0, 31));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
